// File: rtl/ras_pkg.sv
// Shared fetch-stage definitions: RAS control encoding, bundle geometry and
// the return-address helper used by the return address stack.
package ras_pkg;

   localparam int unsigned ADDR_W             = 64;
   localparam int unsigned FETCH_BUNDLE_BYTES = 32;
   localparam int unsigned RAS_DEPTH          = 16;
   localparam int unsigned RAS_PTR_W          = 4;
   localparam int unsigned RAS_CKPT_W         = RAS_PTR_W + RAS_PTR_W + 1;

   localparam logic [1:0] RAS_NONE    = 2'b00;
   localparam logic [1:0] RAS_PUSH    = 2'b01;
   localparam logic [1:0] RAS_POP     = 2'b10;
   localparam logic [1:0] RAS_POPPUSH = 2'b11;

   // Checkpoint width for a given pointer width: {tos, count}.
   function automatic int unsigned ckpt_w(input int unsigned ptr_w);
      return ptr_w + ptr_w + 1;
   endfunction

   // Return address of a call in slot pos of the bundle at pc; wraps mod 2^64.
   function automatic logic [ADDR_W-1:0] push_addr(input logic [ADDR_W-1:0] pc,
                                                   input logic [2:0]        pos);
      return (pc & ~ADDR_W'(FETCH_BUNDLE_BYTES - 1)) + ADDR_W'({pos, 2'b00}) + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/ras_upd.sv
// Combinational RAS next-state function: applies one RAS action to a
// {tos, count} pair and reports the resulting stack write, if any.
module ras_upd
   import ras_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic [PTR_W-1:0]  tos,
   input  logic [PTR_W:0]    count,
   input  logic [1:0]        ctl,
   input  logic [ADDR_W-1:0] addr,
   output logic [PTR_W-1:0]  tos_nxt,
   output logic [PTR_W:0]    count_nxt,
   output logic              we,
   output logic [PTR_W-1:0]  widx,
   output logic [ADDR_W-1:0] wdata
);

   localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

   always_comb begin
      tos_nxt   = tos;
      count_nxt = count;
      we        = 1'b0;
      widx      = tos;
      wdata     = addr;
      case (ctl)
         RAS_PUSH: begin
            // A push into a full stack silently overwrites the oldest entry.
            tos_nxt   = tos + PTR_W'(1);
            widx      = tos + PTR_W'(1);
            we        = 1'b1;
            count_nxt = (count == COUNT_FULL) ? count : count + (PTR_W+1)'(1);
         end
         RAS_POP: begin
            if (count != '0) begin
               tos_nxt   = tos - PTR_W'(1);
               count_nxt = count - (PTR_W+1)'(1);
            end
         end
         RAS_POPPUSH: begin
            we        = 1'b1;
            widx      = tos;
            count_nxt = (count == '0) ? (PTR_W+1)'(1) : count;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ras.sv
// Return address stack for the fetch stage: speculatively updated from the BTB
// prediction, restored from a per-bundle checkpoint on mispredict.
module ras
   import ras_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     pred_vld_i,
   input  logic [ADDR_W-1:0]        pc_f0_i,
   input  logic [2:0]               br_pos_i,
   input  logic [1:0]               ras_ctl_i,
   input  logic                     rcv_i,
   input  logic [PTR_W+PTR_W:0]     rcv_ckpt_i,
   input  logic [1:0]               rcv_ctl_i,
   input  logic [ADDR_W-1:0]        rcv_ret_addr_i,
   output logic                     ras_vld_o,
   output logic [ADDR_W-1:0]        ras_tar_o,
   output logic [PTR_W+PTR_W:0]     ras_ckpt_o
);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  tos;
   logic [PTR_W:0]    count;

   logic [1:0]        pred_ctl;
   logic [ADDR_W-1:0] pred_addr;

   logic [PTR_W-1:0]  p_tos,   r_tos,   n_tos;
   logic [PTR_W:0]    p_cnt,   r_cnt,   n_cnt;
   logic              p_we,    r_we,    n_we;
   logic [PTR_W-1:0]  p_widx,  r_widx,  n_widx;
   logic [ADDR_W-1:0] p_wdata, r_wdata, n_wdata;

   assign pred_ctl  = pred_vld_i ? ras_ctl_i : RAS_NONE;
   assign pred_addr = push_addr(pc_f0_i, br_pos_i);

   // Speculative update from the current prediction.
   ras_upd #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_pred (
      .tos       (tos),
      .count     (count),
      .ctl       (pred_ctl),
      .addr      (pred_addr),
      .tos_nxt   (p_tos),
      .count_nxt (p_cnt),
      .we        (p_we),
      .widx      (p_widx),
      .wdata     (p_wdata)
   );

   // Recovery: restore the checkpoint, then re-apply the branch's true action.
   ras_upd #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rcv (
      .tos       (rcv_ckpt_i[PTR_W+PTR_W:PTR_W+1]),
      .count     (rcv_ckpt_i[PTR_W:0]),
      .ctl       (rcv_ctl_i),
      .addr      (rcv_ret_addr_i),
      .tos_nxt   (r_tos),
      .count_nxt (r_cnt),
      .we        (r_we),
      .widx      (r_widx),
      .wdata     (r_wdata)
   );

   // Recovery wins; the same-cycle prediction is on a path being flushed.
   always_comb begin
      n_tos   = p_tos;
      n_cnt   = p_cnt;
      n_we    = p_we;
      n_widx  = p_widx;
      n_wdata = p_wdata;
      if (rcv_i) begin
         n_tos   = r_tos;
         n_cnt   = r_cnt;
         n_we    = r_we;
         n_widx  = r_widx;
         n_wdata = r_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tos   <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[PTR_W'(i)] <= '0;
         end
      end else begin
         tos   <= n_tos;
         count <= n_cnt;
         if (n_we) begin
            mem[n_widx] <= n_wdata;
         end
      end
   end

   assign ras_vld_o  = (count != '0);
   assign ras_tar_o  = ras_vld_o ? mem[tos] : '0;
   assign ras_ckpt_o = {tos, count};

endmodule
